// File: rtl/uart_xcvr_fifo_if.sv
// Host-side streaming and serial pin bundle for uart_xcvr_fifo.
// The slave modport is the transceiver; the master modport is whatever drives it.
`timescale 1ns/1ps
interface uart_xcvr_fifo_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data_i;
  logic                 tx_valid_i;
  logic                 tx_ready_o;
  logic                 tx_busy_o;
  logic                 tx_o;
  logic                 rx_i;
  logic [DATA_BITS-1:0] rx_data_o;
  logic                 rx_perr_o;
  logic                 rx_ferr_o;
  logic                 rx_break_o;
  logic                 rx_valid_o;
  logic                 rx_ready_i;
  logic                 rx_overflow_o;

  modport slave (
    input  tx_data_i, tx_valid_i, rx_i, rx_ready_i,
    output tx_ready_o, tx_busy_o, tx_o, rx_data_o, rx_perr_o, rx_ferr_o, rx_break_o,
           rx_valid_o, rx_overflow_o
  );

  modport master (
    output tx_data_i, tx_valid_i, rx_i, rx_ready_i,
    input  tx_ready_o, tx_busy_o, tx_o, rx_data_o, rx_perr_o, rx_ferr_o, rx_break_o,
           rx_valid_o, rx_overflow_o
  );
endinterface

// File: rtl/uart_xcvr_fifo.sv
// Parametrised UART transceiver with TX/RX FIFOs, optional parity, 1/2 stop bits and
// parity/framing/break/overflow detection on the receive side.
`timescale 1ns/1ps
module uart_xcvr_fifo #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input logic             clk_i,
  input logic             rst_i,
  uart_xcvr_fifo_if.slave bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int unsigned EW = DATA_BITS + 3;

  localparam logic [CW-1:0] CntOne  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CntBit  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CntHalf = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CntStop = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [3:0]    BitLast = 4'(DATA_BITS - 1);
  localparam logic [AW:0]   PtrOne  = {{AW{1'b0}}, 1'b1};
  localparam logic          HasPar  = (PARITY != 0);
  localparam logic          ParOdd  = (PARITY == 2);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] r_tx_mem [FIFO_DEPTH];
  logic [AW:0]          r_tx_wp, r_tx_rp;
  logic                 w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;
  logic [DATA_BITS-1:0] w_tx_head;

  logic [2:0]           r_tx_state;
  logic [CW-1:0]        r_tx_cnt;
  logic [3:0]           r_tx_bit;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_par;
  logic                 r_tx_o;

  assign w_tx_empty = (r_tx_wp == r_tx_rp);
  assign w_tx_full  = (r_tx_wp[AW] != r_tx_rp[AW]) && (r_tx_wp[AW-1:0] == r_tx_rp[AW-1:0]);
  assign w_tx_head  = r_tx_mem[r_tx_rp[AW-1:0]];
  assign w_tx_push  = bus.tx_valid_i & ~w_tx_full;
  // Pop in IDLE, or at the last stop cycle so the next start bit follows with no gap.
  assign w_tx_pop   = ~w_tx_empty &
                      ((r_tx_state == StIdle) | ((r_tx_state == StStop) & (r_tx_cnt == CntStop)));

  always_ff @(posedge clk_i) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= bus.tx_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tx_wp <= '0;
      r_tx_rp <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + PtrOne;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + PtrOne;
    end
  end

  // ---------------- TX FSM ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tx_state <= StIdle;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx_o     <= 1'b1;
    end else begin
      case (r_tx_state)
        StIdle: begin
          if (w_tx_pop) begin
            r_tx_state <= StStart;
            r_tx_o     <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_shift <= w_tx_head;
            r_tx_par   <= (^w_tx_head) ^ ParOdd;
          end
        end
        StStart: begin
          if (r_tx_cnt == CntBit) begin
            r_tx_state <= StData;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_o     <= r_tx_shift[0];
          end else begin
            r_tx_cnt <= r_tx_cnt + CntOne;
          end
        end
        StData: begin
          if (r_tx_cnt == CntBit) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == BitLast) begin
              r_tx_state <= HasPar ? StParity : StStop;
              r_tx_o     <= HasPar ? r_tx_par : 1'b1;
            end else begin
              r_tx_bit   <= r_tx_bit + 4'd1;
              r_tx_shift <= r_tx_shift >> 1;
              r_tx_o     <= r_tx_shift[1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + CntOne;
          end
        end
        StParity: begin
          if (r_tx_cnt == CntBit) begin
            r_tx_state <= StStop;
            r_tx_cnt   <= '0;
            r_tx_o     <= 1'b1;
          end else begin
            r_tx_cnt <= r_tx_cnt + CntOne;
          end
        end
        StStop: begin
          if (r_tx_cnt == CntStop) begin
            r_tx_cnt <= '0;
            if (w_tx_pop) begin
              r_tx_state <= StStart;
              r_tx_o     <= 1'b0;
              r_tx_shift <= w_tx_head;
              r_tx_par   <= (^w_tx_head) ^ ParOdd;
            end else begin
              r_tx_state <= StIdle;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + CntOne;
          end
        end
        default: begin
          r_tx_state <= StIdle;
          r_tx_o     <= 1'b1;
        end
      endcase
    end
  end

  // ---------------- RX synchroniser ----------------
  logic [1:0] r_rx_sync;
  logic       r_rx_prev;
  logic       w_rxs, w_rx_fall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rx_sync <= 2'b11;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_sync <= {r_rx_sync[0], bus.rx_i};
      r_rx_prev <= w_rxs;
    end
  end

  assign w_rxs     = r_rx_sync[1];
  // A line held low after a frame (break) produces no new edge until it goes high again.
  assign w_rx_fall = r_rx_prev & ~w_rxs;

  // ---------------- RX FSM ----------------
  logic [2:0]           r_rx_state;
  logic [CW-1:0]        r_rx_cnt;
  logic [3:0]           r_rx_bit;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_perr;
  logic                 r_rx_ovf;
  logic                 w_rx_push, w_rx_ferr, w_rx_brk;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rx_state <= StIdle;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_perr  <= 1'b0;
    end else begin
      case (r_rx_state)
        StIdle: begin
          if (w_rx_fall) begin
            r_rx_state <= StStart;
            r_rx_cnt   <= '0;
            r_rx_perr  <= 1'b0;
          end
        end
        StStart: begin
          if (r_rx_cnt == CntHalf) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= w_rxs ? StIdle : StData;
          end else begin
            r_rx_cnt <= r_rx_cnt + CntOne;
          end
        end
        StData: begin
          if (r_rx_cnt == CntBit) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {w_rxs, r_rx_shift[DATA_BITS-1:1]};
            if (r_rx_bit == BitLast) r_rx_state <= HasPar ? StParity : StStop;
            else                     r_rx_bit   <= r_rx_bit + 4'd1;
          end else begin
            r_rx_cnt <= r_rx_cnt + CntOne;
          end
        end
        StParity: begin
          if (r_rx_cnt == CntBit) begin
            r_rx_cnt   <= '0;
            r_rx_perr  <= w_rxs ^ (^r_rx_shift) ^ ParOdd;
            r_rx_state <= StStop;
          end else begin
            r_rx_cnt <= r_rx_cnt + CntOne;
          end
        end
        StStop: begin
          if (r_rx_cnt == CntBit) begin
            r_rx_cnt   <= '0;
            r_rx_state <= StIdle;
          end else begin
            r_rx_cnt <= r_rx_cnt + CntOne;
          end
        end
        default: r_rx_state <= StIdle;
      endcase
    end
  end

  assign w_rx_push = (r_rx_state == StStop) && (r_rx_cnt == CntBit);
  assign w_rx_ferr = ~w_rxs;
  assign w_rx_brk  = ~w_rxs & (r_rx_shift == '0);

  // ---------------- RX FIFO ----------------
  logic [EW-1:0] r_rx_mem [FIFO_DEPTH];
  logic [AW:0]   r_rx_wp, r_rx_rp;
  logic          w_rx_empty, w_rx_full, w_rx_pop, w_rx_accept;
  logic [EW-1:0] w_rx_head;

  assign w_rx_empty  = (r_rx_wp == r_rx_rp);
  assign w_rx_full   = (r_rx_wp[AW] != r_rx_rp[AW]) && (r_rx_wp[AW-1:0] == r_rx_rp[AW-1:0]);
  assign w_rx_pop    = bus.rx_ready_i & ~w_rx_empty;
  assign w_rx_accept = w_rx_push & (~w_rx_full | w_rx_pop);
  assign w_rx_head   = r_rx_mem[r_rx_rp[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (w_rx_accept) r_rx_mem[r_rx_wp[AW-1:0]] <= {w_rx_brk, w_rx_ferr, r_rx_perr, r_rx_shift};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_ovf <= 1'b0;
    end else begin
      if (w_rx_accept) r_rx_wp <= r_rx_wp + PtrOne;
      if (w_rx_pop)    r_rx_rp <= r_rx_rp + PtrOne;
      r_rx_ovf <= w_rx_push & ~w_rx_accept;
    end
  end

  // ---------------- Outputs ----------------
  assign bus.tx_ready_o    = ~w_tx_full;
  assign bus.tx_busy_o     = (r_tx_state != StIdle);
  assign bus.tx_o          = r_tx_o;
  assign bus.rx_data_o     = w_rx_head[DATA_BITS-1:0];
  assign bus.rx_perr_o     = w_rx_head[DATA_BITS];
  assign bus.rx_ferr_o     = w_rx_head[DATA_BITS+1];
  assign bus.rx_break_o    = w_rx_head[DATA_BITS+2];
  assign bus.rx_valid_o    = ~w_rx_empty;
  assign bus.rx_overflow_o = r_rx_ovf;
endmodule

// File: tb/tb_uart_xcvr_fifo.sv
// Bench for uart_xcvr_fifo: instance A (even parity, 1 stop) driven directly,
// instance B (odd parity, 2 stops) run in tx->rx loopback.
`timescale 1ns/1ps
module tb_uart_xcvr_fifo;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst;
  logic rx_drv;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ovf_a   = 0;
  int   ovf_b   = 0;

  always #5 clk = ~clk;

  uart_xcvr_fifo_if #(.DATA_BITS(8)) ifa ();
  uart_xcvr_fifo_if #(.DATA_BITS(8)) ifb ();

  assign ifa.rx_i = rx_drv;
  assign ifb.rx_i = ifb.tx_o;

  uart_xcvr_fifo #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(ifa.slave)
  );

  uart_xcvr_fifo #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(ifb.slave)
  );

  always @(negedge clk) begin
    if (ifa.rx_overflow_o === 1'b1) ovf_a++;
    if (ifb.rx_overflow_o === 1'b1) ovf_b++;
  end

  // Frame bit k (0 = start) of a UART frame with 8 data bits; anything past parity is idle/stop.
  function automatic logic bit_at(input logic [7:0] d, input int par, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9 && par != 0) return (par == 1) ? ^d : ~^d;
    return 1'b1;
  endfunction

  // Expected RX entry {break, ferr, perr, data} for an even-parity frame.
  function automatic logic [10:0] rx_expect(input logic [7:0] d, input logic pbit,
                                            input logic stopb);
    logic perr, ferr, brk;
    perr = (pbit != ^d);
    ferr = ~stopb;
    brk  = ferr && (d == 8'h00);
    return {brk, ferr, perr, d};
  endfunction

  task automatic drive_frame(input logic [7:0] d, input logic pbit, input logic stopb);
    logic [10:0] fr;
    fr = {stopb, pbit, d, 1'b0};
    for (int b = 0; b < 11; b++) begin
      rx_drv = fr[b];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic push_and_capture(input logic [7:0] d, output logic tx_n1,
                                  output logic [49:0] wave, output int busy_cnt);
    @(negedge clk);
    ifa.tx_data_i  = d;
    ifa.tx_valid_i = 1'b1;
    @(negedge clk);
    ifa.tx_valid_i = 1'b0;
    tx_n1    = ifa.tx_o;
    busy_cnt = int'(ifa.tx_busy_o);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      wave[i]  = ifa.tx_o;
      busy_cnt += int'(ifa.tx_busy_o);
    end
  endtask

  function automatic logic [49:0] exp_wave_a(input logic [7:0] d);
    logic [49:0] w;
    for (int i = 0; i < 50; i++) w[i] = bit_at(d, 1, i / CPB);
    return w;
  endfunction

  task automatic test_reset;
    logic [4:0] got;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    got = {ifa.tx_o, ifa.tx_busy_o, ifa.tx_ready_o, ifa.rx_valid_o, ifa.rx_overflow_o};
    n_tests++;
    if (got !== 5'b10100) begin
      n_fail++; $display("FAIL reset_a: got %b want 10100", got);
    end
    got = {ifb.tx_o, ifb.tx_busy_o, ifb.tx_ready_o, ifb.rx_valid_o, ifb.rx_overflow_o};
    n_tests++;
    if (got !== 5'b10100) begin
      n_fail++; $display("FAIL reset_b: got %b want 10100", got);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tx_frame;
    logic [7:0]  d;
    logic        n1;
    logic [49:0] w;
    int          bc;
    for (int f = 0; f < 4; f++) begin
      d = (f == 0) ? 8'hA5 : 8'($urandom);
      push_and_capture(d, n1, w, bc);
      n_tests++;
      if (n1 !== 1'b1) begin
        n_fail++; $display("FAIL tx_latency d=%h: tx_o at N+1 got %b want 1", d, n1);
      end
      n_tests++;
      if (w !== exp_wave_a(d)) begin
        n_fail++; $display("FAIL tx_wave d=%h: got %b want %b", d, w, exp_wave_a(d));
      end
      n_tests++;
      if (bc != 44) begin
        n_fail++; $display("FAIL tx_busy_len d=%h: got %0d want 44", d, bc);
      end
    end
  endtask

  task automatic test_loopback;
    logic [7:0]  q [4];
    logic [11:0] got, exp;
    logic        e;
    int          mism, busy, j, f;
    q[0] = 8'h00; q[1] = 8'hFF; q[2] = 8'h5A; q[3] = 8'($urandom);
    ifb.rx_ready_i = 1'b0;
    mism = 0;
    busy = 0;
    @(negedge clk);
    ifb.tx_data_i  = q[0];
    ifb.tx_valid_i = 1'b1;
    for (int k = 1; k <= 210; k++) begin
      @(negedge clk);
      if (k < 4) ifb.tx_data_i = q[k];
      else       ifb.tx_valid_i = 1'b0;
      busy += int'(ifb.tx_busy_o);
      if (k >= 2) begin
        j = k - 2;
        f = j / 48;
        e = (f < 4) ? bit_at(q[f], 2, (j % 48) / CPB) : 1'b1;
        if (ifb.tx_o !== e) mism++;
      end
    end
    n_tests++;
    if (mism != 0) begin
      n_fail++; $display("FAIL lb_wave: %0d mismatched samples, want 0", mism);
    end
    n_tests++;
    if (busy != 192) begin
      n_fail++; $display("FAIL lb_busy_len: got %0d want 192 (no gap)", busy);
    end
    for (int i = 0; i < 4; i++) begin
      got = {ifb.rx_valid_o, ifb.rx_break_o, ifb.rx_ferr_o, ifb.rx_perr_o, ifb.rx_data_o};
      exp = {4'b1000, q[i]};
      n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL lb_entry%0d: got %h want %h", i, got, exp);
      end
      ifb.rx_ready_i = 1'b1;
      @(negedge clk);
      ifb.rx_ready_i = 1'b0;
    end
    n_tests++;
    if (ifb.rx_valid_o !== 1'b0 || ovf_b != 0) begin
      n_fail++; $display("FAIL lb_drain: valid %b ovf %0d want 0 0", ifb.rx_valid_o, ovf_b);
    end
  endtask

  task automatic test_rx_errors;
    logic [7:0]  d;
    logic        pb, sb;
    logic [11:0] got, exp;
    ifa.rx_ready_i = 1'b0;
    for (int f = 0; f < 8; f++) begin
      if (f == 0) begin
        d = 8'h03; pb = 1'b1; sb = 1'b1;
      end else if (f == 1) begin
        d = 8'h41; pb = ^d; sb = 1'b0;
      end else begin
        d  = 8'($urandom);
        pb = (^d) ^ ($urandom_range(0, 3) == 0);
        sb = ($urandom_range(0, 3) != 0);
      end
      drive_frame(d, pb, sb);
      repeat (6) @(negedge clk);
      got = {ifa.rx_valid_o, ifa.rx_break_o, ifa.rx_ferr_o, ifa.rx_perr_o, ifa.rx_data_o};
      exp = {1'b1, rx_expect(d, pb, sb)};
      n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL rx_entry f%0d: got %h want %h", f, got, exp);
      end
      ifa.rx_ready_i = 1'b1;
      @(negedge clk);
      ifa.rx_ready_i = 1'b0;
      n_tests++;
      if (ifa.rx_valid_o !== 1'b0) begin
        n_fail++; $display("FAIL rx_single f%0d: valid got %b want 0", f, ifa.rx_valid_o);
      end
    end
  endtask

  task automatic test_break;
    logic [11:0] got;
    rx_drv = 1'b0;
    repeat (3 * 11 * CPB) @(negedge clk);
    got = {ifa.rx_valid_o, ifa.rx_break_o, ifa.rx_ferr_o, ifa.rx_perr_o, ifa.rx_data_o};
    n_tests++;
    if (got !== 12'hE00) begin
      n_fail++; $display("FAIL break_entry: got %h want e00", got);
    end
    ifa.rx_ready_i = 1'b1;
    @(negedge clk);
    ifa.rx_ready_i = 1'b0;
    repeat (20) @(negedge clk);
    n_tests++;
    if (ifa.rx_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL break_held: valid got %b want 0", ifa.rx_valid_o);
    end
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    n_tests++;
    if (ifa.rx_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL break_release: valid got %b want 0", ifa.rx_valid_o);
    end
  endtask

  task automatic test_overflow;
    int          ovf0;
    logic [7:0]  d;
    logic [11:0] got, exp;
    ifa.rx_ready_i = 1'b0;
    ovf0 = ovf_a;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        n_tests++;
        if (ovf_a - ovf0 != 0) begin
          n_fail++; $display("FAIL ovf_early: pulses got %0d want 0", ovf_a - ovf0);
        end
      end
      d = 8'h11 + 8'(i);
      drive_frame(d, ^d, 1'b1);
      repeat (3) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    n_tests++;
    if (ovf_a - ovf0 != 1) begin
      n_fail++; $display("FAIL ovf_pulse: pulse cycles got %0d want 1", ovf_a - ovf0);
    end
    for (int i = 0; i < 4; i++) begin
      got = {ifa.rx_valid_o, ifa.rx_break_o, ifa.rx_ferr_o, ifa.rx_perr_o, ifa.rx_data_o};
      exp = {4'b1000, 8'h11 + 8'(i)};
      n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL ovf_entry%0d: got %h want %h", i, got, exp);
      end
      ifa.rx_ready_i = 1'b1;
      @(negedge clk);
      ifa.rx_ready_i = 1'b0;
    end
    n_tests++;
    if (ifa.rx_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL ovf_drain: valid got %b want 0", ifa.rx_valid_o);
    end
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    n_tests++;
    if (ifa.rx_valid_o !== 1'b0 || ovf_a - ovf0 != 1) begin
      n_fail++;
      $display("FAIL glitch: valid %b ovf %0d want 0 1", ifa.rx_valid_o, ovf_a - ovf0);
    end
  endtask

  task automatic test_reset_mid;
    logic [10:0] fr;
    logic [3:0]  got;
    logic [7:0]  d;
    logic        n1;
    logic [49:0] w;
    int          bc, busy, vld;
    @(negedge clk);
    ifa.tx_data_i  = 8'($urandom);
    ifa.tx_valid_i = 1'b1;
    @(negedge clk);
    ifa.tx_data_i  = 8'($urandom);
    @(negedge clk);
    ifa.tx_data_i  = 8'($urandom);
    @(negedge clk);
    ifa.tx_valid_i = 1'b0;
    fr = {1'b1, 1'b0, 8'($urandom), 1'b0};
    for (int b = 0; b < 4; b++) begin
      rx_drv = fr[b];
      repeat (CPB) @(negedge clk);
    end
    n_tests++;
    if (ifa.tx_busy_o !== 1'b1) begin
      n_fail++; $display("FAIL mid_busy: busy before reset got %b want 1", ifa.tx_busy_o);
    end
    rst    = 1'b1;
    rx_drv = 1'b1;
    @(negedge clk);
    got = {ifa.tx_o, ifa.tx_busy_o, ifa.tx_ready_o, ifa.rx_valid_o};
    n_tests++;
    if (got !== 4'b1010) begin
      n_fail++; $display("FAIL mid_reset: {tx,busy,ready,rxv} got %b want 1010", got);
    end
    rst  = 1'b0;
    busy = 0;
    vld  = 0;
    repeat (60) begin
      @(negedge clk);
      busy += int'(ifa.tx_busy_o);
      vld  += int'(ifa.rx_valid_o);
    end
    n_tests++;
    if (busy != 0 || vld != 0) begin
      n_fail++; $display("FAIL mid_quiet: busy %0d rxvalid %0d cycles want 0 0", busy, vld);
    end
    d = 8'($urandom);
    push_and_capture(d, n1, w, bc);
    n_tests++;
    if (n1 !== 1'b1 || w !== exp_wave_a(d) || bc != 44) begin
      n_fail++;
      $display("FAIL mid_retx d=%h: n1 %b busy %0d wave %b want 1 44 %b", d, n1, bc, w,
               exp_wave_a(d));
    end
  endtask

  initial begin
    rst            = 1'b1;
    rx_drv         = 1'b1;
    ifa.tx_data_i  = '0;
    ifa.tx_valid_i = 1'b0;
    ifa.rx_ready_i = 1'b0;
    ifb.tx_data_i  = '0;
    ifb.tx_valid_i = 1'b0;
    ifb.rx_ready_i = 1'b0;
    test_reset();
    test_tx_frame();
    test_loopback();
    test_rx_errors();
    test_break();
    test_overflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_xcvr_fifo.md
Name: uart_xcvr_fifo

Overview:
- Parametrised UART transceiver for DV and emulation top levels.
- Supersedes the fixed 8N1, FIFO-less UART model.
- Adds configurable data width, parity, stop bits, TX/RX FIFOs with valid/ready handshakes, and parity/framing/break/overflow detection.
- Sits between a serial pin pair and a host-side streaming interface: a DPI bridge, a scoreboard, or a UART block under test in loopback.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; integer >= 4
DATA_BITS, 8, data bits per frame; 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits generated on TX; 1 or 2
FIFO_DEPTH, 4, entries in each of the TX and RX FIFOs; power of two >= 2

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
tx_data_i  in  DATA_BITS  byte to transmit
tx_valid_i  in  1  TX push request
tx_ready_o  out  1  TX FIFO not full
tx_busy_o  out  1  serialiser mid-frame
tx_o  out  1  serial output, idle high
rx_i  in  1  serial input, asynchronous
rx_data_o  out  DATA_BITS  head of RX FIFO
rx_perr_o  out  1  parity error flag stored with head entry
rx_ferr_o  out  1  framing error flag stored with head entry
rx_break_o  out  1  break flag stored with head entry (ferr and data == 0)
rx_valid_o  out  1  RX FIFO not empty
rx_ready_i  in  1  RX pop
rx_overflow_o  out  1  one-cycle pulse when a completed frame is dropped

Behaviour:
- Reset, sampled on the clk_i edge with rst_i high:
  - tx_o = 1; tx_busy_o = 0; tx_ready_o = 1; rx_valid_o = 0; rx_overflow_o = 0.
  - Both FIFOs are emptied and both state machines return to IDLE.
  - The rx synchroniser flops are set to 1.
  - Reset mid-frame aborts the frame: tx_o is high in the cycle after reset, and partial RX data is discarded.
- FIFOs:
  - A push occurs on valid & ready.
  - tx_ready_o = !tx_full.
  - rx_valid_o = !rx_empty; entry data and flags are presented combinationally from the head.
  - The RX push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: if the FIFO is non-empty, pop and enter START. tx_o is registered.
  - Latency: a push at cycle N into an empty FIFO with the FSM idle gives tx_o = 0 from cycle N+2.
  - Each bit is held exactly CLKS_PER_BIT cycles. Data is sent LSB first.
  - Parity bit: XOR of the data bits for even parity; its inverse for odd parity.
  - STOP lasts STOP_BITS*CLKS_PER_BIT cycles.
  - Back-to-back frames: the next start bit follows the last stop bit with no idle gap if the FIFO is non-empty.
  - tx_busy_o = 1 in every state other than IDLE.
- RX synchroniser: rx_i passes through a 2-flop synchroniser; all RX logic uses the synchronised signal (rxs).
- RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: a falling edge on rxs enters START and clears the bit counter.
  - START: sample at CLKS_PER_BIT/2 cycles. If rxs = 1, treat it as a glitch: return to IDLE with no push. Otherwise proceed.
  - Each subsequent bit is sampled at CLKS_PER_BIT-cycle intervals from the start mid-point.
  - Parity error: sampled parity differs from the expected value. Always 0 when PARITY = 0.
  - Only the first stop bit is checked; a 0 there sets ferr.
  - break = ferr & (data == 0).
  - After the stop sample, push {data, perr, ferr, break}. rx_valid_o rises the next cycle when the FIFO was empty.
  - If the push is refused because the FIFO is full, drop the frame, pulse rx_overflow_o for one cycle, and leave the FIFO contents unchanged.
  - After the stop sample the FSM returns to IDLE immediately. If rxs is still 0 (break), no new start is recognised until rxs has returned to 1.
- TX and RX are fully independent, so simultaneous activity is allowed.

Test Plan:
1. CLKS_PER_BIT=4, DATA_BITS=8, PARITY=1, STOP_BITS=1; push 0xA5 -> tx_o reads 0,1,0,1,0,0,1,0,1,0,1, each bit 4 cycles; start at N+2; tx_busy_o high for 44 cycles.
2. Loopback tx_o -> rx_i, PARITY=2, STOP_BITS=2; push 0x00, 0xFF, 0x5A back-to-back -> three RX entries in order with perr = ferr = break = 0; no idle gap between TX frames.
3. PARITY=1; drive a frame for 0x03 with parity bit 1 -> rx_data_o = 0x03, rx_perr_o = 1, rx_ferr_o = 0.
4. Drive a frame for 0x41 with stop = 0 -> ferr = 1, break = 0. Then hold rx_i low for 3 frame times -> exactly one entry with data 0x00, ferr = 1, break = 1; no further entries until rx_i returns high.
5. FIFO_DEPTH=4, rx_ready_i = 0; receive 0x11..0x15 -> entries 0x11..0x14 kept; one rx_overflow_o pulse after the fifth frame. Then pop 4 -> rx_valid_o drops. Also: a 1-cycle low glitch on rx_i -> no entry.
6. Assert rst_i mid-TX at bit 3 with 2 entries queued and mid-RX frame -> tx_o = 1 next cycle, tx_ready_o = 1, rx_valid_o = 0, no entry pushed; a new push transmits normally.
